// File: rtl/dcache_cmu.sv
// Direct-mapped, write-back, write-allocate data cache for the MIPS MEM stage.
// Misses run a word-serial write-back/refill on a req/ack memory bus.
module dcache_cmu #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LINE_NUM   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_rw,
  input  logic        en_r,
  input  logic        en_w,
  input  logic [31:0] data_w,
  output logic [31:0] data_r,
  output logic        stall,
  output logic        mem_cs_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINE_NUM);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_BACK, S_FILL, S_WAIT} state_t;

  state_t state, next_state;

  logic [TAG_W-1:0] tag_mem  [LINE_NUM];
  logic [31:0]      data_mem [LINE_NUM*LINE_WORDS];
  logic [LINE_NUM-1:0] valid_bits, dirty_bits;

  logic [OFF_W-1:0] cnt;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req, hit, miss, wr_hit, last, fill_done;
  logic             unused_addr;

  assign req_off     = addr_rw[2 +: OFF_W];
  assign req_idx     = addr_rw[2+OFF_W +: IDX_W];
  assign req_tag     = addr_rw[31 -: TAG_W];
  assign unused_addr = ^addr_rw[1:0];

  assign req       = en_r | en_w;
  assign hit       = req & valid_bits[req_idx] & (tag_mem[req_idx] == req_tag);
  assign miss      = req & ~hit;
  assign wr_hit    = en_w & hit & (state == S_IDLE);
  assign last      = (cnt == OFF_W'(LINE_WORDS - 1));
  assign fill_done = (state == S_FILL) & mem_ack_i & last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (miss) next_state = (valid_bits[req_idx] & dirty_bits[req_idx]) ? S_BACK : S_FILL;
      S_BACK: if (mem_ack_i && last) next_state = S_FILL;
      S_FILL: if (mem_ack_i && last) next_state = S_WAIT;
      S_WAIT: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (state)
      S_BACK: begin
        mem_cs_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_mem[miss_idx], miss_idx, cnt, 2'b00};
        mem_data_o = data_mem[{miss_idx, cnt}];
      end
      S_FILL: begin
        mem_cs_o   = 1'b1;
        mem_addr_o = {miss_tag, miss_idx, cnt, 2'b00};
      end
      default: ;
    endcase
    stall  = ~rst & ((state != S_IDLE) | miss);
    data_r = (~rst & en_r & hit) ? data_mem[{req_idx, req_off}] : '0;
  end

  // Miss target is latched so a withdrawn request cannot redirect the refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (miss) begin
            miss_idx <= req_idx;
            miss_tag <= req_tag;
          end
        end
        S_BACK, S_FILL: if (mem_ack_i) cnt <= last ? '0 : cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else if (fill_done) begin
      valid_bits[miss_idx] <= 1'b1;
      dirty_bits[miss_idx] <= 1'b0;
    end else if (wr_hit) begin
      dirty_bits[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (state == S_FILL && mem_ack_i) data_mem[{miss_idx, cnt}] <= mem_data_i;
    else if (wr_hit)                  data_mem[{req_idx, req_off}] <= data_w;
    if (fill_done) tag_mem[miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_dcache_cmu.sv
// Directed self-checking bench for dcache_cmu with a behavioural word-serial memory.
module tb_dcache_cmu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_rw, data_w, data_r;
  logic        en_r, en_w, stall;
  logic        mem_cs_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [1024];
  int          wait_cycles;
  int          wcnt;
  logic [31:0] rd_addr[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  dcache_cmu #(.LINE_WORDS(4), .LINE_NUM(64)) dut (
    .clk(clk), .rst(rst), .addr_rw(addr_rw), .en_r(en_r), .en_w(en_w),
    .data_w(data_w), .data_r(data_r), .stall(stall),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  assign mem_ack_i  = mem_cs_o && (wcnt >= wait_cycles);
  assign mem_data_i = mem_model[mem_addr_o[11:2]];

  always @(posedge clk) begin
    if (mem_cs_o && !mem_ack_i) wcnt <= wcnt + 1;
    else                        wcnt <= 0;
    if (mem_cs_o && mem_ack_i) begin
      if (mem_we_o) begin
        wr_addr.push_back(mem_addr_o);
        wr_data.push_back(mem_data_o);
        mem_model[mem_addr_o[11:2]] = mem_data_o;
      end else begin
        rd_addr.push_back(mem_addr_o);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs;
    rd_addr.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en_r = 1'b1; en_w = 1'b0; addr_rw = 32'h40; data_w = '0;
    #3;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++; if (data_r !== 32'h0) begin n_fail++; $display("FAIL reset_data_r: got %h expected 0", data_r); end
    n_checks++; if ({mem_cs_o, mem_we_o} !== 2'b00) begin n_fail++; $display("FAIL reset_cs_we: got %b expected 00", {mem_cs_o, mem_we_o}); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
    tick(); tick();
    en_r = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss;
    int n;
    logic [31:0] exp_a;
    clear_logs();
    en_r = 1'b1; addr_rw = 32'h40;
    #1;
    wait_stall(n);
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL cold_stall_cycles: got %0d expected 6", n); end
    n_checks++; if (rd_addr.size() !== 4) begin n_fail++; $display("FAIL cold_read_count: got %0d expected 4", rd_addr.size()); end
    else for (int k = 0; k < 4; k++) begin
      exp_a = 32'h40 + 32'(4 * k);
      n_checks++; if (rd_addr[k] !== exp_a) begin n_fail++; $display("FAIL cold_read_addr%0d: got %h expected %h", k, rd_addr[k], exp_a); end
    end
    n_checks++; if (data_r !== 32'hA0) begin n_fail++; $display("FAIL cold_data_r: got %h expected 000000a0", data_r); end
    tick();
    en_r = 1'b0;
  endtask

  task automatic test_write_hit_read;
    en_w = 1'b1; addr_rw = 32'h44; data_w = 32'hDEADBEEF;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wh_store_stall: got %b expected 0", stall); end
    tick();
    en_w = 1'b0; en_r = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wh_load_stall: got %b expected 0", stall); end
    n_checks++; if (data_r !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wh_load_data: got %h expected deadbeef", data_r); end
    n_checks++; if (dut.dirty_bits[4] !== 1'b1) begin n_fail++; $display("FAIL wh_dirty: got %b expected 1", dut.dirty_bits[4]); end
    tick();
    en_r = 1'b0;
  endtask

  task automatic test_dirty_evict;
    int n;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hDEADBEEF; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    clear_logs();
    en_r = 1'b1; addr_rw = 32'h440;
    #1;
    wait_stall(n);
    n_checks++; if (n !== 10) begin n_fail++; $display("FAIL evict_stall_cycles: got %0d expected 10", n); end
    n_checks++; if (wr_addr.size() !== 4) begin n_fail++; $display("FAIL evict_write_count: got %0d expected 4", wr_addr.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_checks++; if (wr_addr[k] !== 32'h40 + 32'(4 * k)) begin n_fail++; $display("FAIL evict_wr_addr%0d: got %h expected %h", k, wr_addr[k], 32'h40 + 32'(4 * k)); end
      n_checks++; if (wr_data[k] !== exp_d[k]) begin n_fail++; $display("FAIL evict_wr_data%0d: got %h expected %h", k, wr_data[k], exp_d[k]); end
    end
    n_checks++; if (rd_addr.size() !== 4) begin n_fail++; $display("FAIL evict_read_count: got %0d expected 4", rd_addr.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_checks++; if (rd_addr[k] !== 32'h440 + 32'(4 * k)) begin n_fail++; $display("FAIL evict_rd_addr%0d: got %h expected %h", k, rd_addr[k], 32'h440 + 32'(4 * k)); end
    end
    n_checks++; if (data_r !== 32'hB0) begin n_fail++; $display("FAIL evict_data_r: got %h expected 000000b0", data_r); end
    tick();
    en_r = 1'b0;
  endtask

  task automatic test_wait_states;
    int n;
    wait_cycles = 3;
    clear_logs();
    // clean fill of line 0 with 3 wait cycles per word
    en_r = 1'b1; addr_rw = 32'h800;
    #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({mem_cs_o, mem_ack_i, mem_addr_o} !== {2'b10, 32'h800}) begin n_fail++; $display("FAIL ws_fill_hold%0d: got cs/ack/addr %b%b %h expected 10 00000800", i, mem_cs_o, mem_ack_i, mem_addr_o); end
      tick();
    end
    n_checks++; if ({mem_ack_i, mem_addr_o} !== {1'b1, 32'h800}) begin n_fail++; $display("FAIL ws_fill_ack: got ack/addr %b %h expected 1 00000800", mem_ack_i, mem_addr_o); end
    tick();
    n_checks++; if ({mem_ack_i, mem_addr_o} !== {1'b0, 32'h804}) begin n_fail++; $display("FAIL ws_fill_adv: got ack/addr %b %h expected 0 00000804", mem_ack_i, mem_addr_o); end
    wait_stall(n);
    n_checks++; if (n !== 13) begin n_fail++; $display("FAIL ws_fill_remaining: got %0d expected 13", n); end
    n_checks++; if (data_r !== 32'hC0) begin n_fail++; $display("FAIL ws_fill_data: got %h expected 000000c0", data_r); end
    n_checks++; if (rd_addr.size() !== 4 || rd_addr[3] !== 32'h80C) begin n_fail++; $display("FAIL ws_fill_reads: got %0d reads expected 4 ending at 0000080c", rd_addr.size()); end
    tick();
    // dirty line 0, then evict it with wait states
    en_r = 1'b0; en_w = 1'b1; data_w = 32'h77;
    tick();
    en_w = 1'b0; en_r = 1'b1; addr_rw = 32'h0;
    clear_logs();
    #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({mem_we_o, mem_ack_i, mem_addr_o, mem_data_o} !== {2'b10, 32'h800, 32'h77}) begin n_fail++; $display("FAIL ws_back_hold%0d: got we/ack/addr/data %b%b %h %h expected 10 00000800 00000077", i, mem_we_o, mem_ack_i, mem_addr_o, mem_data_o); end
      tick();
    end
    n_checks++; if ({mem_ack_i, mem_addr_o} !== {1'b1, 32'h800}) begin n_fail++; $display("FAIL ws_back_ack: got ack/addr %b %h expected 1 00000800", mem_ack_i, mem_addr_o); end
    tick();
    wait_stall(n);
    n_checks++; if (n !== 29) begin n_fail++; $display("FAIL ws_back_remaining: got %0d expected 29", n); end
    n_checks++; if (data_r !== 32'h1000) begin n_fail++; $display("FAIL ws_back_data: got %h expected 00001000", data_r); end
    n_checks++; if (wr_data.size() !== 4 || wr_data[0] !== 32'h77) begin n_fail++; $display("FAIL ws_back_writes: got %0d writes expected 4 starting with 00000077", wr_data.size()); end
    tick();
    en_r = 1'b0;
    wait_cycles = 0;
  endtask

  task automatic test_reset_mid_fill;
    int n;
    en_r = 1'b1; addr_rw = 32'hC40;
    #1;
    tick();
    tick();
    n_checks++; if ({mem_cs_o, mem_addr_o} !== {1'b1, 32'hC44}) begin n_fail++; $display("FAIL rmf_second_word: got cs/addr %b %h expected 1 00000c44", mem_cs_o, mem_addr_o); end
    rst = 1'b1;
    #1;
    n_checks++; if ({mem_cs_o, stall} !== 2'b00) begin n_fail++; $display("FAIL rmf_drop: got cs/stall %b expected 00", {mem_cs_o, stall}); end
    en_r = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    en_r = 1'b1; addr_rw = 32'h440;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmf_post_miss: got %b expected 1", stall); end
    wait_stall(n);
    n_checks++; if (n !== 6) begin n_fail++; $display("FAIL rmf_refill_cycles: got %0d expected 6", n); end
    n_checks++; if (data_r !== 32'hB0) begin n_fail++; $display("FAIL rmf_refill_data: got %h expected 000000b0", data_r); end
    tick();
    en_r = 1'b0;
  endtask

  task automatic test_rw_both;
    en_r = 1'b1; en_w = 1'b1; addr_rw = 32'h448; data_w = 32'h12345678;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rw_stall: got %b expected 0", stall); end
    tick();
    en_w = 1'b0;
    #1;
    n_checks++; if (dut.dirty_bits[4] !== 1'b1) begin n_fail++; $display("FAIL rw_dirty: got %b expected 1", dut.dirty_bits[4]); end
    n_checks++; if (data_r !== 32'h12345678) begin n_fail++; $display("FAIL rw_data: got %h expected 12345678", data_r); end
    tick();
    en_r = 1'b0;
  endtask

  task automatic test_withdrawn;
    int n;
    en_w = 1'b1; addr_rw = 32'hF0; data_w = 32'h55;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wd_miss_stall: got %b expected 1", stall); end
    tick();
    en_w = 1'b0;
    #1;
    wait_stall(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL wd_remaining: got %0d expected 5", n); end
    en_r = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wd_hit_stall: got %b expected 0", stall); end
    n_checks++; if (data_r !== 32'h103C) begin n_fail++; $display("FAIL wd_data: got %h expected 0000103c", data_r); end
    n_checks++; if (dut.dirty_bits[15] !== 1'b0) begin n_fail++; $display("FAIL wd_dirty: got %b expected 0", dut.dirty_bits[15]); end
    tick();
    en_r = 1'b0;
  endtask

  initial begin
    wait_cycles = 0;
    wcnt = 0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h1000 + 32'(i);
    for (int k = 0; k < 4; k++) begin
      mem_model[16 + k]    = 32'hA0 + 32'(k);
      mem_model[272 + k]   = 32'hB0 + 32'(k);
      mem_model[512 + k]   = 32'hC0 + 32'(k);
      mem_model[784 + k]   = 32'hD0 + 32'(k);
    end
    test_reset();
    test_cold_miss();
    test_write_hit_read();
    test_dirty_evict();
    test_wait_states();
    test_reset_mid_fill();
    test_rw_both();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
